read_port_arbiter: RTL and testbench
====================================

READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4, memory address width.
REQ-002 SHALL have parameter DATA_WDTH, default 32, read data width.
REQ-003 SHALL have parameter RESP_WDTH, default 1, read response width.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port m_ar_valid  in  2  per-requester read address valid; bit k belongs to requester k.
REQ-007 SHALL have port m_ar_ready  out  2  per-requester read address accept.
REQ-008 SHALL have port m_ar_address  in  2*ADDR_WDTH  requester k address in bits [k*ADDR_WDTH +: ADDR_WDTH].
REQ-009 SHALL have port m_r_valid  out  2  per-requester read data valid.
REQ-010 SHALL have port m_r_ready  in  2  per-requester read data ready.
REQ-011 SHALL have port m_r_data  out  DATA_WDTH  read data, broadcast to both requesters.
REQ-012 SHALL have port m_r_resp  out  RESP_WDTH  read response, broadcast to both requesters.
REQ-013 SHALL have port s_ar_valid  out  1  memory read address valid.
REQ-014 SHALL have port s_ar_ready  in  1  memory read address accept.
REQ-015 SHALL have port s_ar_address  out  ADDR_WDTH  memory read address.
REQ-016 SHALL have port s_r_valid  in  1  memory read data valid.
REQ-017 SHALL have port s_r_ready  out  1  memory read data ready.
REQ-018 SHALL have port s_r_data  in  DATA_WDTH  memory read data.
REQ-019 SHALL have port s_r_resp  in  RESP_WDTH  memory read response.
REQ-020 SHALL have port grant  out  2  one-hot registered owner of the port; 2'b00 when idle.

Function
REQ-021 SHALL implement FSM with states IDLE, ADDR and DATA, held in registers.
REQ-022 IDLE: with any m_ar_valid bit set at a clock edge, SHALL register grant per REQ-023 and enter ADDR; otherwise stay in IDLE.
REQ-023 Simultaneous requests SHALL be resolved by the priority rule in Configuration; a lone request always wins.
REQ-024 ADDR: s_ar_valid = m_ar_valid[g], s_ar_address = address of g, m_ar_ready[g] = s_ar_ready, where g is the granted index; the other requester's m_ar_ready SHALL be 0.
REQ-025 ADDR SHALL move to DATA on the edge where s_ar_valid and s_ar_ready are both 1; a granted requester dropping m_ar_valid SHALL leave the FSM in ADDR.
REQ-026 DATA: m_r_valid[g] = s_r_valid, s_r_ready = m_r_ready[g]; m_r_data/m_r_resp SHALL follow s_r_data/s_r_resp in every state.
REQ-027 DATA SHALL return to IDLE and clear grant on the edge of the s_r_valid/s_r_ready handshake; nonzero s_r_resp SHALL be passed through unchanged and not affect sequencing.
REQ-028 In IDLE: s_ar_valid, s_r_ready, m_ar_ready and m_r_valid SHALL be 0; s_r_valid outside DATA SHALL be ignored.
REQ-029 Minimum per-transaction latency SHALL be: request edge -> ADDR (1 cycle), AR handshake -> DATA, R handshake -> IDLE; one IDLE cycle between back-to-back grants.
REQ-030 Only one read outstanding at a time; no second AR SHALL be issued before the R handshake completes.

Reset
REQ-031 rst high SHALL immediately force IDLE, grant=2'b00, priority pointer=0, so all handshake outputs drop to 0 asynchronously, including mid-transaction.
REQ-032 After rst falls, first arbitration SHALL occur on the next rising edge with any m_ar_valid set.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN defined: 1-bit pointer names the preferred requester on contention; after each completed R handshake pointer = index of the other requester.
REQ-034 ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins contention; no pointer register.

Verification
REQ-035 Lone req: m_ar_valid=01, addr0=4'h3, s_ar_ready=1, s_r_data=32'hA5 next -> grant=01, s_ar_address=3, m_r_valid=01 with data A5, IDLE after 3 edges.
REQ-036 Contention RR: m_ar_valid=11 held for 4 transactions -> grant sequence 01,10,01,10; without macro 01,01,01,01.
REQ-037 Backpressure: s_ar_ready=0 for 5 cycles then 1, m_r_ready[g]=0 for 3 cycles -> FSM holds ADDR then DATA, s_r_ready=0 until m_r_ready set, no data lost.
REQ-038 Error pass-through: s_r_resp=1 on requester 1 read -> m_r_resp=1 with m_r_valid=10, next grant proceeds normally.
REQ-039 Reset mid-DATA: rst=1 while grant=10 -> grant=00, s_r_ready=0, m_r_valid=00 same cycle; after release m_ar_valid=11 -> grant=01.

Source files
------------

// File: rtl/read_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : read_port_arbiter                                               |
// | Brief    : Two-requester arbiter sharing one memory read port, one read in |
// |            flight at a time. Define ARB_ROUND_ROBIN_EN for round-robin     |
// |            contention handling; otherwise requester 0 has fixed priority.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module read_port_arbiter #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             m_ar_valid,
  output logic [1:0]             m_ar_ready,
  input  logic [2*ADDR_WDTH-1:0] m_ar_address,
  output logic [1:0]             m_r_valid,
  input  logic [1:0]             m_r_ready,
  output logic [DATA_WDTH-1:0]   m_r_data,
  output logic [RESP_WDTH-1:0]   m_r_resp,
  output logic                   s_ar_valid,
  input  logic                   s_ar_ready,
  output logic [ADDR_WDTH-1:0]   s_ar_address,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  input  logic [DATA_WDTH-1:0]   s_r_data,
  input  logic [RESP_WDTH-1:0]   s_r_resp,
  output logic [1:0]             grant
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_addr = 2'd1;
  localparam logic [1:0] c_data = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [1:0] r_grant;
  logic [1:0] w_next_grant;
  logic       w_g;
  logic       w_pref;
  logic       w_win;
  logic       w_ar_hs;
  logic       w_r_hs;

  // Granted index; only meaningful while r_grant is one-hot.
  assign w_g     = r_grant[1];
  assign w_ar_hs = (r_state == c_addr) && m_ar_valid[w_g] && s_ar_ready;
  assign w_r_hs  = (r_state == c_data) && s_r_valid && m_r_ready[w_g];

`ifdef ARB_ROUND_ROBIN_EN
  logic r_ptr;

  // Hand preference to the other requester once a read fully completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_r_hs) begin
      r_ptr <= ~w_g;
    end
  end

  assign w_pref = r_ptr;
`else
  assign w_pref = 1'b0;
`endif

  assign w_win = (m_ar_valid == 2'b11) ? w_pref : m_ar_valid[1];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_next_state;
      r_grant <= w_next_grant;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_next_grant = r_grant;
    case (r_state)
      c_idle: begin
        if (|m_ar_valid) begin
          w_next_state = c_addr;
          w_next_grant = w_win ? 2'b10 : 2'b01;
        end
      end
      c_addr: begin
        if (w_ar_hs) begin
          w_next_state = c_data;
        end
      end
      c_data: begin
        if (w_r_hs) begin
          w_next_state = c_idle;
          w_next_grant = 2'b00;
        end
      end
      default: begin
        w_next_state = c_idle;
        w_next_grant = 2'b00;
      end
    endcase
  end

  // Output logic.
  always_comb begin
    s_ar_valid = 1'b0;
    m_ar_ready = 2'b00;
    s_r_ready  = 1'b0;
    m_r_valid  = 2'b00;
    case (r_state)
      c_addr: begin
        s_ar_valid = m_ar_valid[w_g];
        m_ar_ready = r_grant & {2{s_ar_ready}};
      end
      c_data: begin
        s_r_ready = m_r_ready[w_g];
        m_r_valid = r_grant & {2{s_r_valid}};
      end
      default: begin
      end
    endcase
  end

  assign s_ar_address = w_g ? m_ar_address[2*ADDR_WDTH-1:ADDR_WDTH]
                            : m_ar_address[ADDR_WDTH-1:0];
  assign m_r_data     = s_r_data;
  assign m_r_resp     = s_r_resp;
  assign grant        = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_read_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_read_port_arbiter                                            |
// | Brief    : Directed self-checking bench for read_port_arbiter.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_read_port_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  m_ar_valid;
  logic [1:0]  m_ar_ready;
  logic [7:0]  m_ar_address;
  logic [1:0]  m_r_valid;
  logic [1:0]  m_r_ready;
  logic [31:0] m_r_data;
  logic [0:0]  m_r_resp;
  logic        s_ar_valid;
  logic        s_ar_ready;
  logic [3:0]  s_ar_address;
  logic        s_r_valid;
  logic        s_r_ready;
  logic [31:0] s_r_data;
  logic [0:0]  s_r_resp;
  logic [1:0]  grant;

  int n_checks;
  int n_errors;

  read_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .m_ar_valid   (m_ar_valid),
    .m_ar_ready   (m_ar_ready),
    .m_ar_address (m_ar_address),
    .m_r_valid    (m_r_valid),
    .m_r_ready    (m_r_ready),
    .m_r_data     (m_r_data),
    .m_r_resp     (m_r_resp),
    .s_ar_valid   (s_ar_valid),
    .s_ar_ready   (s_ar_ready),
    .s_ar_address (s_ar_address),
    .s_r_valid    (s_r_valid),
    .s_r_ready    (s_r_ready),
    .s_r_data     (s_r_data),
    .s_r_resp     (s_r_resp),
    .grant        (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    m_ar_valid = 2'b00;
    m_r_ready  = 2'b00;
    s_ar_ready = 1'b0;
    s_r_valid  = 1'b0;
    s_r_resp   = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  // One complete read with ready memory: grant edge, AR edge, R edge.
  task automatic run_txn(input logic [1:0] req, input logic [1:0] exp_g,
                         input logic [3:0] exp_addr, input logic [31:0] data,
                         input logic [0:0] resp, input string tag);
    m_ar_valid = req;
    s_ar_ready = 1'b1;
    m_r_ready  = 2'b11;
    s_r_valid  = 1'b0;
    step();
    chk({tag, "_grant"}, {30'd0, grant}, {30'd0, exp_g});
    chk({tag, "_araddr"}, {28'd0, s_ar_address}, {28'd0, exp_addr});
    chk({tag, "_arready"}, {30'd0, m_ar_ready}, {30'd0, exp_g});
    s_r_valid = 1'b1;
    s_r_data  = data;
    s_r_resp  = resp;
    step();
    chk({tag, "_rvalid"}, {30'd0, m_r_valid}, {30'd0, exp_g});
    chk({tag, "_rdata"}, m_r_data, data);
    chk({tag, "_rresp"}, {31'd0, m_r_resp}, {31'd0, resp});
    step();
    s_r_valid = 1'b0;
    #1;
    chk({tag, "_idle"}, {30'd0, grant}, 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    m_ar_address = {4'hC, 4'h3};
    s_r_data     = 32'h0;
    do_reset();
    rst = 1'b1;
    step();
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_arvalid", {31'd0, s_ar_valid}, 32'd0);
    rst = 1'b0;

    // Stray memory data while idle must be ignored.
    s_r_valid = 1'b1;
    m_r_ready = 2'b11;
    s_r_data  = 32'h5A5A;
    #1;
    chk("idle_rvalid", {30'd0, m_r_valid}, 32'd0);
    chk("idle_rready", {31'd0, s_r_ready}, 32'd0);
    chk("idle_rdata", m_r_data, 32'h5A5A);
    s_r_valid = 1'b0;

    // Lone request from requester 0.
    m_ar_valid = 2'b01;
    s_ar_ready = 1'b1;
    step();
    chk("lone_grant", {30'd0, grant}, 32'd1);
    chk("lone_arvalid", {31'd0, s_ar_valid}, 32'd1);
    chk("lone_araddr", {28'd0, s_ar_address}, 32'h3);
    s_r_valid = 1'b1;
    s_r_data  = 32'hA5;
    #1;
    chk("lone_addr_rvalid", {30'd0, m_r_valid}, 32'd0);
    chk("lone_addr_rready", {31'd0, s_r_ready}, 32'd0);
    step();
    m_ar_valid = 2'b00;
    #1;
    chk("lone_rvalid", {30'd0, m_r_valid}, 32'd1);
    chk("lone_rdata", m_r_data, 32'hA5);
    chk("lone_data_arvalid", {31'd0, s_ar_valid}, 32'd0);
    step();
    chk("lone_idle", {30'd0, grant}, 32'd0);
    s_r_valid = 1'b0;

    // Contention held across four reads.
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    run_txn(2'b11, 2'b01, 4'h3, 32'h11, 1'b0, "cont0");
    run_txn(2'b11, 2'b10, 4'hC, 32'h22, 1'b0, "cont1");
    run_txn(2'b11, 2'b01, 4'h3, 32'h33, 1'b0, "cont2");
    run_txn(2'b11, 2'b10, 4'hC, 32'h44, 1'b0, "cont3");
`else
    run_txn(2'b11, 2'b01, 4'h3, 32'h11, 1'b0, "cont0");
    run_txn(2'b11, 2'b01, 4'h3, 32'h22, 1'b0, "cont1");
    run_txn(2'b11, 2'b01, 4'h3, 32'h33, 1'b0, "cont2");
    run_txn(2'b11, 2'b01, 4'h3, 32'h44, 1'b0, "cont3");
`endif

    // Backpressure on both channels for requester 1.
    do_reset();
    m_ar_valid = 2'b10;
    step();
    chk("bp_grant", {30'd0, grant}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_addr_hold", {31'd0, s_ar_valid}, 32'd1);
      chk("bp_addr_noready", {30'd0, m_ar_ready}, 32'd0);
      step();
    end
    s_ar_ready = 1'b1;
    s_r_valid  = 1'b1;
    s_r_data   = 32'hDEADBEEF;
    m_r_ready  = 2'b01;
    #1;
    chk("bp_arready", {30'd0, m_ar_ready}, 32'd2);
    step();
    m_ar_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data_rready", {31'd0, s_r_ready}, 32'd0);
      chk("bp_data_rvalid", {30'd0, m_r_valid}, 32'd2);
      chk("bp_data_rdata", m_r_data, 32'hDEADBEEF);
      step();
    end
    m_r_ready = 2'b10;
    #1;
    chk("bp_rready", {31'd0, s_r_ready}, 32'd1);
    step();
    s_r_valid = 1'b0;
    chk("bp_idle", {30'd0, grant}, 32'd0);

    // Error response on requester 1, then a normal read.
    do_reset();
    run_txn(2'b10, 2'b10, 4'hC, 32'h1234, 1'b1, "err");
    run_txn(2'b01, 2'b01, 4'h3, 32'h5678, 1'b0, "after_err");

    // Asynchronous reset while requester 1 is in the data phase.
    do_reset();
    m_ar_valid = 2'b10;
    s_ar_ready = 1'b1;
    step();
    s_r_valid = 1'b1;
    m_r_ready = 2'b11;
    step();
    chk("mid_rready", {31'd0, s_r_ready}, 32'd1);
    chk("mid_grant", {30'd0, grant}, 32'd2);
    rst = 1'b1;
    #1;
    chk("rstmid_grant", {30'd0, grant}, 32'd0);
    chk("rstmid_rready", {31'd0, s_r_ready}, 32'd0);
    chk("rstmid_rvalid", {30'd0, m_r_valid}, 32'd0);
    rst        = 1'b0;
    s_r_valid  = 1'b0;
    m_ar_valid = 2'b11;
    step();
    chk("rstmid_regrant", {30'd0, grant}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
